// File: rtl/ray_pixel_scheduler.sv
// ray_pixel_scheduler
// Raster-order pixel sequencer feeding the ray generator. Ray issue is
// metered by tracer credits. Each issued coordinate is also carried through
// a LATENCY-deep delay line so it leaves aligned with the generator's
// ray_valid for that pixel.
module ray_pixel_scheduler #(
    parameter int WIDTH   = 1280,
    parameter int HEIGHT  = 720,
    parameter int LATENCY = 28,
    parameter int CREDITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        credit_return,
    output logic [10:0] pixel_h,
    output logic [9:0]  pixel_v,
    output logic        new_ray,
    output logic [10:0] pixel_h_aligned,
    output logic [9:0]  pixel_v_aligned,
    output logic        aligned_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        credit_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [10:0]   H_LAST   = 11'(WIDTH - 1);
    localparam logic [9:0]    V_LAST   = 10'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [10:0]   h;
    logic [9:0]    v;
    logic [CW-1:0] credit_count;

    // Delay line stages: index 0 is fed by the registered issue outputs,
    // index LATENCY-1 drives the aligned outputs.
    logic          vld_p [LATENCY];
    logic [10:0]   h_p   [LATENCY];
    logic [9:0]    v_p   [LATENCY];

    logic          issue;
    logic          line_busy;

    // Issue decision uses the credit count before this cycle's return.
    always_comb begin
        issue = (state == ISSUE) && (credit_count != '0);
    end

    // Any ray still travelling through the issue register or delay line.
    always_comb begin
        line_busy = new_ray;
        for (int i = 0; i < LATENCY; i++) begin
            line_busy = line_busy | vld_p[i];
        end
    end

    // Frame sequencing FSM with registered issue and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            h          <= '0;
            v          <= '0;
            new_ray    <= 1'b0;
            pixel_h    <= '0;
            pixel_v    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            new_ray    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        h     <= '0;
                        v     <= '0;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        new_ray <= 1'b1;
                        pixel_h <= h;
                        pixel_v <= v;
                        if (h == H_LAST) begin
                            h <= '0;
                            if (v == V_LAST) begin
                                v     <= '0;
                                state <= DRAIN;
                            end else begin
                                v <= v + 10'd1;
                            end
                        end else begin
                            h <= h + 11'd1;
                        end
                    end
                end
                DRAIN: begin
                    // Frame is complete once every credit is home and no
                    // aligned output is still pending.
                    if ((credit_count == CRED_MAX) && !line_busy) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Credit counter: issue consumes, return refills, saturating at CREDITS.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_count <= CRED_MAX;
            credit_err   <= 1'b0;
        end else begin
            if (issue && !credit_return) begin
                credit_count <= credit_count - 1'b1;
            end else if (!issue && credit_return) begin
                if (credit_count == CRED_MAX) begin
                    credit_err <= 1'b1;
                end else begin
                    credit_count <= credit_count + 1'b1;
                end
            end
        end
    end

    // Coordinate delay line, shifting every cycle regardless of state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i] <= 1'b0;
                h_p[i]   <= '0;
                v_p[i]   <= '0;
            end
        end else begin
            vld_p[0] <= new_ray;
            h_p[0]   <= pixel_h;
            v_p[0]   <= pixel_v;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                h_p[i]   <= h_p[i-1];
                v_p[i]   <= v_p[i-1];
            end
        end
    end

    assign aligned_valid   = vld_p[LATENCY-1];
    assign pixel_h_aligned = h_p[LATENCY-1];
    assign pixel_v_aligned = v_p[LATENCY-1];

endmodule

// File: tb/tb_ray_pixel_scheduler.sv
// tb_ray_pixel_scheduler
// Directed bench for ray_pixel_scheduler using three instances:
// dut_a (4x2, 8 credits, latency 5), dut_b (4x2, 3 credits, latency 5) and
// dut_c (40x18, 8 credits, latency 28) for a long credit-metered frame.
module tb_ray_pixel_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dut_a signals
    logic rst_a, start_a, ret_a;
    logic [10:0] ph_a, pha_a;
    logic [9:0]  pv_a, pva_a;
    logic nr_a, av_a, busy_a, fd_a, err_a;
    // dut_b signals
    logic rst_b, start_b, ret_b;
    logic [10:0] ph_b, pha_b;
    logic [9:0]  pv_b, pva_b;
    logic nr_b, av_b, busy_b, fd_b, err_b;
    // dut_c signals
    logic rst_c, start_c, ret_c;
    logic [10:0] ph_c, pha_c;
    logic [9:0]  pv_c, pva_c;
    logic nr_c, av_c, busy_c, fd_c, err_c;

    ray_pixel_scheduler #(.WIDTH(4), .HEIGHT(2), .LATENCY(5), .CREDITS(8)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .credit_return(ret_a),
        .pixel_h(ph_a), .pixel_v(pv_a), .new_ray(nr_a),
        .pixel_h_aligned(pha_a), .pixel_v_aligned(pva_a), .aligned_valid(av_a),
        .busy(busy_a), .frame_done(fd_a), .credit_err(err_a));

    ray_pixel_scheduler #(.WIDTH(4), .HEIGHT(2), .LATENCY(5), .CREDITS(3)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .credit_return(ret_b),
        .pixel_h(ph_b), .pixel_v(pv_b), .new_ray(nr_b),
        .pixel_h_aligned(pha_b), .pixel_v_aligned(pva_b), .aligned_valid(av_b),
        .busy(busy_b), .frame_done(fd_b), .credit_err(err_b));

    ray_pixel_scheduler #(.WIDTH(40), .HEIGHT(18), .LATENCY(28), .CREDITS(8)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .credit_return(ret_c),
        .pixel_h(ph_c), .pixel_v(pv_c), .new_ray(nr_c),
        .pixel_h_aligned(pha_c), .pixel_v_aligned(pva_c), .aligned_valid(av_c),
        .busy(busy_c), .frame_done(fd_c), .credit_err(err_c));

    logic [10:0] hist_h [8192];
    logic [9:0]  hist_v [8192];
    bit          hist_vld [8192];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1; rst_b = 1; rst_c = 1;
        start_a = 0; start_b = 0; start_c = 0;
        ret_a = 0; ret_b = 0; ret_c = 0;
        repeat (3) tick();
        checks++; if (nr_a !== 1'b0)  begin errors++; $display("FAIL reset_new_ray: got %b expected 0", nr_a); end
        checks++; if (ph_a !== 11'd0) begin errors++; $display("FAIL reset_pixel_h: got %0d expected 0", ph_a); end
        checks++; if (pv_a !== 10'd0) begin errors++; $display("FAIL reset_pixel_v: got %0d expected 0", pv_a); end
        checks++; if (av_a !== 1'b0)  begin errors++; $display("FAIL reset_aligned_valid: got %b expected 0", av_a); end
        checks++; if (pha_a !== 11'd0 || pva_a !== 10'd0) begin errors++; $display("FAIL reset_aligned_xy: got %0d,%0d expected 0,0", pha_a, pva_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (fd_a !== 1'b0)  begin errors++; $display("FAIL reset_frame_done: got %b expected 0", fd_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_credit_err: got %b expected 0", err_a); end
        checks++; if ({nr_b, busy_b, err_b, nr_c, busy_c, err_c} !== 6'b0) begin errors++; $display("FAIL reset_b_c: got %b expected 000000", {nr_b, busy_b, err_b, nr_c, busy_c, err_c}); end
        rst_a = 0; rst_b = 0; rst_c = 0;
        repeat (2) tick();
        checks++; if ({nr_a, busy_a, av_a, fd_a} !== 4'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected 0000", {nr_a, busy_a, av_a, fd_a}); end
    endtask

    task automatic test_credit_err_idle();
        ret_a = 1;
        tick();
        ret_a = 0;
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL credit_err_set: got %b expected 1", err_a); end
        repeat (4) tick();
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL credit_err_sticky: got %b expected 1", err_a); end
        checks++; if (busy_a !== 1'b0 || nr_a !== 1'b0) begin errors++; $display("FAIL credit_err_idle: got busy=%b new_ray=%b expected 0,0", busy_a, nr_a); end
    endtask

    // Full 4x2 frame with credit_return held high; optional ignored start.
    task automatic test_full_frame(input bit mid_start);
        int eh, ev, ah, av;
        bit en, ea;
        ret_a = 1;
        start_a = 1;
        tick();
        start_a = 0;
        checks++; if (busy_a !== 1'b1 || nr_a !== 1'b0) begin errors++; $display("FAIL ff_start: got busy=%b new_ray=%b expected 1,0", busy_a, nr_a); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            en = (k >= 1 && k <= 8);
            ea = (k >= 6 && k <= 13);
            eh = (k - 1) % 4;  ev = (k - 1) / 4;
            ah = (k - 6) % 4;  av = (k - 6) / 4;
            checks++; if (nr_a !== en) begin errors++; $display("FAIL ff_new_ray k=%0d: got %b expected %b", k, nr_a, en); end
            if (en) begin
                checks++; if (ph_a !== 11'(eh) || pv_a !== 10'(ev)) begin errors++; $display("FAIL ff_coord k=%0d: got %0d,%0d expected %0d,%0d", k, ph_a, pv_a, eh, ev); end
            end
            checks++; if (av_a !== ea) begin errors++; $display("FAIL ff_aligned_valid k=%0d: got %b expected %b", k, av_a, ea); end
            if (ea) begin
                checks++; if (pha_a !== 11'(ah) || pva_a !== 10'(av)) begin errors++; $display("FAIL ff_aligned_coord k=%0d: got %0d,%0d expected %0d,%0d", k, pha_a, pva_a, ah, av); end
            end
            checks++; if (fd_a !== (k == 15)) begin errors++; $display("FAIL ff_frame_done k=%0d: got %b expected %b", k, fd_a, (k == 15)); end
            checks++; if (busy_a !== (k < 15)) begin errors++; $display("FAIL ff_busy k=%0d: got %b expected %b", k, busy_a, (k < 15)); end
            start_a = (mid_start && k == 3);
        end
        start_a = 0;
        ret_a = 0;
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL ff_err_sticky: got %b expected 1", err_a); end
    endtask

    task automatic test_reset_mid_frame();
        int n_fd, n_av, n_nr;
        bit seen;
        ret_a = 0;
        start_a = 1;
        tick();
        start_a = 0;
        repeat (3) tick();
        checks++; if (nr_a !== 1'b1 || ph_a !== 11'd2 || pv_a !== 10'd0) begin errors++; $display("FAIL rst_third_issue: got nr=%b %0d,%0d expected 1 2,0", nr_a, ph_a, pv_a); end
        rst_a = 1;
        tick();
        rst_a = 0;
        checks++; if (nr_a !== 1'b0) begin errors++; $display("FAIL rst_new_ray: got %b expected 0", nr_a); end
        checks++; if (av_a !== 1'b0) begin errors++; $display("FAIL rst_aligned_valid: got %b expected 0", av_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rst_credit_err: got %b expected 0", err_a); end
        n_fd = 0; n_av = 0; n_nr = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_fd += int'(fd_a);
            n_av += int'(av_a);
            n_nr += int'(nr_a);
        end
        checks++; if (n_fd != 0) begin errors++; $display("FAIL rst_no_frame_done: got %0d pulses expected 0", n_fd); end
        checks++; if (n_av != 0) begin errors++; $display("FAIL rst_flushed_line: got %0d aligned expected 0", n_av); end
        checks++; if (n_nr != 0) begin errors++; $display("FAIL rst_no_issue: got %0d issues expected 0", n_nr); end
        // Restart; returns sampled exactly on the eight issue edges.
        start_a = 1;
        tick();
        start_a = 0;
        ret_a = 1;
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                checks++; if (nr_a !== 1'b1 || ph_a !== 11'd0 || pv_a !== 10'd0) begin errors++; $display("FAIL restart_first: got nr=%b %0d,%0d expected 1 0,0", nr_a, ph_a, pv_a); end
            end
            if (k == 8) ret_a = 0;
            if (fd_a) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL restart_frame_done: got 0 expected 1"); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL restart_credit_err: got %b expected 0", err_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL restart_busy: got %b expected 0", busy_a); end
    endtask

    // CREDITS=3 instance: starvation, zero-count return, one-count return.
    task automatic test_credit_metering();
        bit seen;
        ret_b = 0;
        start_b = 1;
        tick();
        start_b = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++; if (nr_b !== (k <= 3)) begin errors++; $display("FAIL cm_new_ray k=%0d: got %b expected %b", k, nr_b, (k <= 3)); end
            if (k <= 3) begin
                checks++; if (ph_b !== 11'(k - 1) || pv_b !== 10'd0) begin errors++; $display("FAIL cm_coord k=%0d: got %0d,%0d expected %0d,0", k, ph_b, pv_b, k - 1); end
            end
        end
        // Return at count 0: no issue on that edge, issue on the next.
        ret_b = 1;
        tick();
        ret_b = 0;
        checks++; if (nr_b !== 1'b0) begin errors++; $display("FAIL cm_zero_return_same: got %b expected 0", nr_b); end
        tick();
        checks++; if (nr_b !== 1'b1 || ph_b !== 11'd3 || pv_b !== 10'd0) begin errors++; $display("FAIL cm_one_more: got nr=%b %0d,%0d expected 1 3,0", nr_b, ph_b, pv_b); end
        repeat (3) tick();
        checks++; if (nr_b !== 1'b0) begin errors++; $display("FAIL cm_starved_again: got %b expected 0", nr_b); end
        // Count 0 -> 1, then issue together with a return keeps count at 1.
        ret_b = 1;
        tick();
        checks++; if (nr_b !== 1'b0) begin errors++; $display("FAIL cm_refill: got %b expected 0", nr_b); end
        tick();
        ret_b = 0;
        checks++; if (nr_b !== 1'b1 || ph_b !== 11'd0 || pv_b !== 10'd1) begin errors++; $display("FAIL cm_issue_with_return: got nr=%b %0d,%0d expected 1 0,1", nr_b, ph_b, pv_b); end
        tick();
        checks++; if (nr_b !== 1'b1 || ph_b !== 11'd1 || pv_b !== 10'd1) begin errors++; $display("FAIL cm_count_held: got nr=%b %0d,%0d expected 1 1,1", nr_b, ph_b, pv_b); end
        tick();
        checks++; if (nr_b !== 1'b0) begin errors++; $display("FAIL cm_empty_after: got %b expected 0", nr_b); end
        // Finish the frame: count 0->1, then two issues with returns.
        ret_b = 1;
        tick();
        tick();
        checks++; if (nr_b !== 1'b1 || ph_b !== 11'd2 || pv_b !== 10'd1) begin errors++; $display("FAIL cm_coord_21: got nr=%b %0d,%0d expected 1 2,1", nr_b, ph_b, pv_b); end
        tick();
        checks++; if (nr_b !== 1'b1 || ph_b !== 11'd3 || pv_b !== 10'd1) begin errors++; $display("FAIL cm_coord_31: got nr=%b %0d,%0d expected 1 3,1", nr_b, ph_b, pv_b); end
        // Count is 1; two more returns bring it to 3.
        tick();
        tick();
        ret_b = 0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (fd_b) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL cm_frame_done: got 0 expected 1"); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL cm_busy_end: got %b expected 0", busy_b); end
        checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL cm_credit_err: got %b expected 0", err_b); end
    endtask

    // 40x18 frame, latency 28, each credit returned 40 cycles after issue.
    task automatic test_long_frame();
        int q[$];
        int t, n_issue, n_al;
        int exp_h, exp_v, last_h, last_v;
        bit done, okal;
        for (int i = 0; i < 8192; i++) hist_vld[i] = 0;
        ret_c = 0;
        start_c = 1;
        tick();
        start_c = 0;
        t = 0; n_issue = 0; n_al = 0; exp_h = 0; exp_v = 0;
        last_h = -1; last_v = -1; done = 0;
        while (!done && t < 8000) begin
            tick();
            t++;
            if (nr_c) begin
                checks++; if (ph_c !== 11'(exp_h) || pv_c !== 10'(exp_v)) begin errors++; $display("FAIL lf_coord t=%0d: got %0d,%0d expected %0d,%0d", t, ph_c, pv_c, exp_h, exp_v); end
                hist_vld[t] = 1;
                hist_h[t] = 11'(exp_h);
                hist_v[t] = 10'(exp_v);
                last_h = int'(ph_c); last_v = int'(pv_c);
                n_issue++;
                q.push_back(t + 40);
                if (exp_h == 39) begin exp_h = 0; exp_v++; end else exp_h++;
            end
            if (av_c) begin
                n_al++;
                okal = 0;
                if (t >= 28) okal = hist_vld[t-28] && (pha_c === hist_h[t-28]) && (pva_c === hist_v[t-28]);
                checks++; if (!okal) begin errors++; $display("FAIL lf_aligned t=%0d: got %0d,%0d not matching issue 28 cycles earlier", t, pha_c, pva_c); end
            end
            if (fd_c) done = 1;
            ret_c = (q.size() > 0 && q[0] == t + 1);
            if (ret_c) void'(q.pop_front());
        end
        ret_c = 0;
        checks++; if (!done) begin errors++; $display("FAIL lf_timeout: got no frame_done in %0d cycles expected pulse", t); end
        checks++; if (n_issue != 720) begin errors++; $display("FAIL lf_issue_count: got %0d expected 720", n_issue); end
        checks++; if (n_al != 720) begin errors++; $display("FAIL lf_aligned_count: got %0d expected 720", n_al); end
        checks++; if (last_h != 39 || last_v != 17) begin errors++; $display("FAIL lf_last_pixel: got %0d,%0d expected 39,17", last_h, last_v); end
        checks++; if (err_c !== 1'b0) begin errors++; $display("FAIL lf_credit_err: got %b expected 0", err_c); end
    endtask

    initial begin
        test_reset();
        test_credit_err_idle();
        test_full_frame(1'b0);
        test_full_frame(1'b1);
        test_reset_mid_frame();
        test_credit_metering();
        test_long_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ray_pixel_scheduler.md
Name: ray_pixel_scheduler

Overview:
- Upstream pixel sequencer for `ray_maker`. Walks the frame in raster order and drives `pixel_h`, `pixel_v` and `new_ray` into the ray generator.
- `ray_maker` has fixed latency and no backpressure. This block therefore meters issue with credits returned by the downstream tracer.
- It also delays each pixel coordinate by the ray generator's latency, so the coordinate leaves aligned with that pixel's `ray_valid`.

Parameters:
- WIDTH, 1280, pixels per row.
- HEIGHT, 720, rows per frame.
- LATENCY, 28, cycles from `new_ray` to `ray_valid` in the ray generator. Must be at least 1.
- CREDITS, 8, tracer input-buffer slots. This is the maximum number of outstanding rays. Must be at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a frame. Accepted only in IDLE.
- credit_return  in  1  one pulse per ray the tracer has consumed from its buffer.
- pixel_h  out  11  column of the issued ray. Valid while `new_ray` is high.
- pixel_v  out  10  row of the issued ray. Valid while `new_ray` is high.
- new_ray  out  1  one-cycle issue strobe to the ray generator.
- pixel_h_aligned  out  11  `pixel_h` delayed by LATENCY cycles.
- pixel_v_aligned  out  10  `pixel_v` delayed by LATENCY cycles.
- aligned_valid  out  1  `new_ray` delayed by LATENCY cycles. Coincides with `ray_valid`.
- busy  out  1  high in ISSUE and DRAIN.
- frame_done  out  1  one-cycle pulse when a frame has completely drained.
- credit_err  out  1  sticky flag: a credit was returned while the count was already at CREDITS.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0. Internal state is IDLE, h=0, v=0, credit_count=CREDITS. The delay line is all zero, including its valid bits.
- States and transitions:
  - IDLE -> ISSUE on `start`. Loads h=0, v=0.
  - ISSUE -> DRAIN on the cycle that issues pixel (WIDTH-1, HEIGHT-1).
  - DRAIN -> IDLE once credit_count==CREDITS and no valid bits remain in the delay line. `frame_done` pulses on that transition edge.
- Issue rule (ISSUE only):
  - A ray is issued in a cycle iff credit_count != 0, evaluated before that cycle's `credit_return`.
  - On issue, the next cycle has new_ray=1, pixel_h=h, pixel_v=v.
  - h increments. At WIDTH-1, h wraps to 0 and v increments.
  - With no credit, new_ray=0 and h/v hold. `pixel_h`/`pixel_v` hold their last values (don't-care).
- Credit arithmetic, per cycle:
  - Issue and return together: count unchanged.
  - Issue only: count - 1.
  - Return only: count + 1, saturating at CREDITS. A saturating return sets `credit_err`, which is cleared only by `rst`.
  - The count never underflows, because issue is gated on a nonzero count.
- Delay line:
  - LATENCY-deep shift register of {valid, h, v}, fed by the registered `new_ray`/`pixel_h`/`pixel_v`.
  - `aligned_valid` equals `new_ray` from exactly LATENCY cycles earlier; `pixel_h_aligned`/`pixel_v_aligned` carry that cycle's coordinates.
  - It shifts every cycle regardless of state.
- `start` while `busy`: ignored, with no effect on the frame in progress.
- `credit_return` in IDLE: counted and saturated by the same rules.
- `rst` mid-frame: returns everything to reset values next cycle, flushes the delay line, and produces no `frame_done`.
- Throughput: one ray per cycle when credits are sufficient. Steady state with a tracer return rate r is min(1, r).
- `pixel_h`/`pixel_v` are unsigned. The downstream centering arithmetic (WIDTH/2 - h) is not this block's concern.

Test Plan:
- WIDTH=4, HEIGHT=2, CREDITS=8, LATENCY=5, `credit_return` held high. Pulse `start` -> `new_ray` high for 8 consecutive cycles starting 1 cycle after `start`. Coordinates (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1). `aligned_valid` repeats the same 8-cycle sequence 5 cycles later. `frame_done` pulses once after the last aligned output. `busy` is 0 afterwards.
- CREDITS=3, no returns, WIDTH=4, HEIGHT=2 -> exactly 3 issues, then `new_ray` stays 0. A single `credit_return` pulse -> exactly one further issue, at (3,0).
- credit_count=0 and `credit_return`=1 in the same cycle -> no issue that cycle, issue next cycle. Credit_count=1 with a return -> issue occurs and the count stays 1.
- In IDLE with count=CREDITS, pulse `credit_return` -> `credit_err`=1 and stays high. Count remains CREDITS, and the next frame issues normally.
- Second `start` mid-frame -> ignored, with the coordinate sequence uninterrupted. Assert `rst` at the 3rd issue -> next cycle `new_ray`=0, `aligned_valid`=0, `busy`=0. No `frame_done`. A new `start` restarts at (0,0).
- Default parameters, with each credit returned 40 cycles after its ray's issue -> total of 921600 issues. The last ray is at (1279,719). `pixel_h_aligned`/`pixel_v_aligned` equal `pixel_h`/`pixel_v` from 28 cycles earlier for every ray.
